// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and decode-side handshake bundles for decode_stage
interface decode_fetch_if #(parameter int XLEN = 32);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] r_rv1;
  logic [XLEN-1:0] r_rv2;
  modport master(output instr_valid, instr, pc_in, r_rv1, r_rv2, input instr_ready);
  modport slave(input instr_valid, instr, pc_in, r_rv1, r_rv2, output instr_ready);
endinterface

interface decode_out_if #(parameter int XLEN = 32, parameter int OP_W = 6);
  logic            dec_valid;
  logic            dec_ready;
  logic [OP_W-1:0] op;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_out;
  logic            we;
  logic            illegal;
  modport master(output dec_valid, op, rs1, rs2, rd, rv1, rv2, imm, pc_out, we, illegal, input dec_ready);
  modport slave(input dec_valid, op, rs1, rs2, rd, rv1, rv2, imm, pc_out, we, illegal, output dec_ready);
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M) decoder with output register plus skid entry
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int OP_W    = 6,
  parameter int EN_MEXT = 0,
  parameter int ZERO_RD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  decode_fetch_if.slave i_fetch,
  decode_out_if.master  o_dec
);
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            we;
    logic            ill;
  } ent_t;

  logic [31:0]     w_in;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [5:0]      w_code;
  logic [XLEN-1:0] w_imm, w_rv2;
  logic            w_ill, w_nowr, w_we, w_accept;
  ent_t            w_ent;
  ent_t            r_out, r_skid;
  logic            r_out_v, r_skid_v;

  assign w_in    = i_fetch.instr;
  assign w_opc   = w_in[6:0];
  assign w_f3    = w_in[14:12];
  assign w_f7    = w_in[31:25];
  assign w_imm_i = XLEN'($signed(w_in[31:20]));
  assign w_imm_s = XLEN'($signed({w_in[31:25], w_in[11:7]}));
  assign w_imm_b = XLEN'($signed({w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({w_in[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0}));

  // Decode opcode/funct fields into op code, immediate, operand 2 and legality
  always_comb begin
    w_code = 6'd0;
    w_ill  = 1'b0;
    w_nowr = 1'b0;
    w_imm  = '0;
    w_rv2  = i_fetch.r_rv2;
    case (w_opc)
      7'b0010011: begin
        w_imm = w_imm_i;
        w_rv2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? XLEN'(w_in[24:20]) : w_imm_i;
        case (w_f3)
          3'b000:  w_code = 6'd0;
          3'b010:  w_code = 6'd1;
          3'b011:  w_code = 6'd2;
          3'b100:  w_code = 6'd3;
          3'b110:  w_code = 6'd4;
          3'b111:  w_code = 6'd5;
          3'b001:  begin w_code = 6'd6; w_ill = w_f7 != 7'b0000000; end
          default: begin w_code = w_f7[5] ? 6'd7 : 6'd8; w_ill = {w_f7[6], w_f7[4:0]} != 6'b0; end
        endcase
      end
      7'b0110011: begin
        case (w_f7)
          7'b0000000: w_code = (w_f3 >= 3'd5) ? 6'd11 + {3'b0, w_f3} : 6'd10 + {3'b0, w_f3};
          7'b0100000: begin w_code = (w_f3 == 3'b000) ? 6'd9 : 6'd15; w_ill = w_f3 != 3'b000 && w_f3 != 3'b101; end
          7'b0000001: begin w_code = 6'd37 + {3'b0, w_f3}; w_ill = EN_MEXT == 0; end
          default:    w_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        w_imm  = w_imm_i;
        w_code = (w_f3 < 3'd3) ? 6'd19 + {3'b0, w_f3} : 6'd18 + {3'b0, w_f3};
        w_ill  = w_f3 == 3'd3 || w_f3 > 3'd5;
      end
      7'b0100011: begin
        w_imm  = w_imm_s;
        w_nowr = 1'b1;
        w_code = 6'd24 + {3'b0, w_f3};
        w_ill  = w_f3 > 3'd2;
      end
      7'b1100011: begin
        w_imm  = w_imm_b;
        w_nowr = 1'b1;
        w_code = (w_f3 < 3'd2) ? 6'd27 + {3'b0, w_f3} : 6'd25 + {3'b0, w_f3};
        w_ill  = w_f3 == 3'd2 || w_f3 == 3'd3;
      end
      7'b1101111: begin w_imm = w_imm_j; w_code = 6'd33; end
      7'b1100111: begin w_imm = w_imm_i; w_code = 6'd34; w_ill = w_f3 != 3'b000; end
      7'b0110111: begin w_imm = w_imm_u; w_code = 6'd35; end
      7'b0010111: begin w_imm = w_imm_u; w_code = 6'd36; end
      default:    w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_code = 6'd0;
      w_rv2  = i_fetch.r_rv2;
    end
  end

  assign w_we     = ~w_ill & ~w_nowr & ~(ZERO_RD != 0 && w_in[11:7] == 5'd0);
  assign w_accept = i_fetch.instr_valid & i_fetch.instr_ready;
  assign w_ent    = '{op: OP_W'(w_code), rs1: w_in[19:15], rs2: w_in[24:20], rd: w_in[11:7],
                      rv1: i_fetch.r_rv1, rv2: w_rv2, imm: w_imm, pc: i_fetch.pc_in, we: w_we, ill: w_ill};

  // Ready depends only on registered skid state, never on dec_ready
  assign i_fetch.instr_ready = ~r_skid_v & ~reset;

  assign o_dec.dec_valid = r_out_v;
  assign o_dec.op        = r_out.op;
  assign o_dec.rs1       = r_out.rs1;
  assign o_dec.rs2       = r_out.rs2;
  assign o_dec.rd        = r_out.rd;
  assign o_dec.rv1       = r_out.rv1;
  assign o_dec.rv2       = r_out.rv2;
  assign o_dec.imm       = r_out.imm;
  assign o_dec.pc_out    = r_out.pc;
  assign o_dec.we        = r_out.we;
  assign o_dec.illegal   = r_out.ill;

  // Output register refills from skid first, then from a new accept; stalled accepts park in skid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out    <= '0;
      r_skid   <= '0;
    end else if (flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_out_v || o_dec.dec_ready) begin
      r_out_v  <= r_skid_v | w_accept;
      r_skid_v <= 1'b0;
      if (r_skid_v) r_out <= r_skid;
      else if (w_accept) r_out <= w_ent;
    end else if (w_accept) begin
      r_skid   <= w_ent;
      r_skid_v <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage decode and skid handshake
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  decode_fetch_if #(.XLEN(32)) f();
  decode_out_if #(.XLEN(32), .OP_W(6)) d();
  decode_fetch_if #(.XLEN(32)) fm();
  decode_out_if #(.XLEN(32), .OP_W(6)) dm();

  decode_stage #(.XLEN(32), .OP_W(6), .EN_MEXT(0), .ZERO_RD(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .i_fetch(f), .o_dec(d));
  decode_stage #(.XLEN(32), .OP_W(6), .EN_MEXT(1), .ZERO_RD(1)) u_mext (
    .clk(clk), .reset(reset), .flush(flush), .i_fetch(fm), .o_dec(dm));

  assign fm.instr_valid = f.instr_valid;
  assign fm.instr       = f.instr;
  assign fm.pc_in       = f.pc_in;
  assign fm.r_rv1       = f.r_rv1;
  assign fm.r_rv2       = f.r_rv2;
  assign dm.dec_ready   = 1'b1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins);
    f.instr       = ins;
    f.pc_in       = 32'h0000_1000;
    f.r_rv1       = 32'hAAAA_5555;
    f.r_rv2       = 32'h1234_5678;
    f.instr_valid = 1'b1;
  endtask

  task automatic vec(input string tag, input logic [31:0] ins, input int op, input logic we,
                     input logic ill, input logic [31:0] imm, input logic [31:0] rv2);
    put(ins);
    step();
    f.instr_valid = 1'b0;
    chk({tag, " valid"}, d.dec_valid, 1);
    chk({tag, " op"}, d.op, op);
    chk({tag, " we"}, d.we, we);
    chk({tag, " illegal"}, d.illegal, ill);
    chk({tag, " imm"}, d.imm, imm);
    chk({tag, " rv2"}, d.rv2, rv2);
    chk({tag, " rv1"}, d.rv1, 32'hAAAA_5555);
    chk({tag, " pc"}, d.pc_out, 32'h0000_1000);
  endtask

  initial begin
    f.instr_valid = 1'b0;
    f.instr = 32'h0;
    f.pc_in = 32'h0;
    f.r_rv1 = 32'h0;
    f.r_rv2 = 32'h0;
    d.dec_ready = 1'b1;
    #1;
    chk("rst valid", d.dec_valid, 0);
    chk("rst ready", f.instr_ready, 0);
    chk("rst op", d.op, 0);
    chk("rst rv2", d.rv2, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("post-rst ready", f.instr_ready, 1);

    vec("addi", 32'hFFB10093, 0, 1, 0, 32'hFFFFFFFB, 32'hFFFFFFFB);
    chk("addi rd", d.rd, 1);
    chk("addi rs1", d.rs1, 2);
    vec("srai", 32'h40725193, 7, 1, 0, 32'h00000407, 32'h7);
    vec("sw", 32'hFE532C23, 26, 0, 0, 32'hFFFFFFF8, 32'h12345678);
    chk("sw rs2", d.rs2, 5);
    vec("beq", 32'hFE208EE3, 27, 0, 0, 32'hFFFFFFFC, 32'h12345678);
    vec("add", 32'h002081B3, 10, 1, 0, 32'h0, 32'h12345678);
    vec("sub", 32'h402081B3, 9, 1, 0, 32'h0, 32'h12345678);
    vec("xor-f7", 32'h4020C1B3, 0, 0, 1, 32'h0, 32'h12345678);
    vec("lui", 32'h123452B7, 35, 1, 0, 32'h12345000, 32'h12345678);
    vec("mul-noM", 32'h027302B3, 0, 0, 1, 32'h0, 32'h12345678);
    chk("mul-M valid", dm.dec_valid, 1);
    chk("mul-M op", dm.op, 37);
    chk("mul-M we", dm.we, 1);
    chk("mul-M illegal", dm.illegal, 0);
    chk("mul-M rv2", dm.rv2, 32'h12345678);
    vec("nop-x0", 32'h00000013, 0, 0, 0, 32'h0, 32'h0);
    vec("all-ones", 32'hFFFFFFFF, 0, 0, 1, 32'h0, 32'h12345678);
    step();
    chk("idle valid", d.dec_valid, 0);

    d.dec_ready = 1'b0;
    put(32'hFFB10093);
    step();
    put(32'h40725193);
    chk("stall A op", d.op, 0);
    chk("stall A ready", f.instr_ready, 1);
    step();
    put(32'h002081B3);
    chk("skid full ready", f.instr_ready, 0);
    chk("skid full valid", d.dec_valid, 1);
    chk("hold A op", d.op, 0);
    step();
    chk("C stalled op", d.op, 0);
    chk("C stalled ready", f.instr_ready, 0);
    d.dec_ready = 1'b1;
    step();
    chk("order B op", d.op, 7);
    chk("order B ready", f.instr_ready, 1);
    step();
    f.instr_valid = 1'b0;
    chk("order C op", d.op, 10);
    chk("order C valid", d.dec_valid, 1);
    step();
    chk("drain valid", d.dec_valid, 0);

    d.dec_ready = 1'b0;
    put(32'hFFB10093);
    step();
    put(32'h40725193);
    step();
    f.instr_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush valid", d.dec_valid, 0);
    chk("flush ready", f.instr_ready, 1);
    d.dec_ready = 1'b1;
    step();
    chk("no stale skid", d.dec_valid, 0);
    put(32'h002081B3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    f.instr_valid = 1'b0;
    chk("flush beats accept", d.dec_valid, 0);

    d.dec_ready = 1'b0;
    put(32'hFFB10093);
    step();
    put(32'h40725193);
    step();
    f.instr_valid = 1'b0;
    chk("refill skid ready", f.instr_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst valid", d.dec_valid, 0);
    chk("async rst ready", f.instr_ready, 0);
    chk("async rst op", d.op, 0);
    step();
    reset = 1'b0;
    d.dec_ready = 1'b1;
    step();
    chk("after rst valid", d.dec_valid, 0);
    chk("after rst ready", f.instr_ready, 1);
    step();
    chk("after rst no stale", d.dec_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
